// File: rtl/tick_pkg.sv
// Shared defaults and FSM encoding for the tick scheduler and its round-robin arbiter.
package tick_pkg;

  localparam int DEF_COUNT_WIDTH = 20;
  localparam int DEF_SLOTS       = 4;
  localparam int DEF_DIVISOR     = 50000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RELOAD = 2'd2
  } tickState_e;

  // A single consumer still needs a 1-bit index so port widths never collapse to zero.
  function automatic int idxWidth(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/rr_slot_arbiter.sv
// Combinational round-robin pick: first requester strictly after the pointer, wrapping,
// so the pointer's own slot wins only when it is the sole requester.
module rr_slot_arbiter
  import tick_pkg::*;
#(
  parameter int   SLOTS = DEF_SLOTS,
  localparam int  IDX_W = idxWidth(SLOTS)
) (
  input  logic [SLOTS-1:0] request,
  input  logic [IDX_W-1:0] pointer,
  output logic [SLOTS-1:0] grant,
  output logic [IDX_W-1:0] index,
  output logic             found
);

  logic [IDX_W-1:0] candIdx;

  // Scan farthest-first so the nearest requester after the pointer is the last to overwrite.
  always_comb begin
    grant   = '0;
    index   = '0;
    found   = 1'b0;
    candIdx = '0;
    for (int off = SLOTS; off >= 1; off--) begin
      candIdx = IDX_W'((int'(pointer) + off) % SLOTS);
      if (request[candIdx]) begin
        grant          = '0;
        grant[candIdx] = 1'b1;
        index          = candIdx;
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Programmable tick generator that hands each tick period to one requesting slot in
// round-robin order; divisor changes pass through a one-cycle RELOAD state.
//
// state  | meaning
// IDLE   | stopped; counter held at 0, no ticks, divisor may be offered
// RUN    | counting; tick pulses once every divisor cycles
// RELOAD | one cycle; pending divisor becomes active, counter cleared
module tick_scheduler
  import tick_pkg::*;
#(
  parameter int  COUNT_WIDTH     = DEF_COUNT_WIDTH,
  parameter int  SLOTS           = DEF_SLOTS,
  parameter int  DEFAULT_DIVISOR = DEF_DIVISOR,
  localparam int IDX_W           = idxWidth(SLOTS)
) (
  input  logic                   cmosClock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   cfgValid,
  input  logic [COUNT_WIDTH-1:0] cfgDivisor,
  output logic                   cfgReady,
  input  logic [SLOTS-1:0]       slotRequest,
  output logic                   tick,
  output logic [SLOTS-1:0]       slotGrant,
  output logic [IDX_W-1:0]       slotIndex,
  output logic                   running
);

  localparam logic [COUNT_WIDTH-1:0] DIV_RESET = COUNT_WIDTH'(DEFAULT_DIVISOR);
  localparam logic [COUNT_WIDTH-1:0] ONE       = COUNT_WIDTH'(1);

  tickState_e state;
  tickState_e nextState;

  logic [COUNT_WIDTH-1:0] counter;
  logic [COUNT_WIDTH-1:0] divisor;
  logic [COUNT_WIDTH-1:0] pendingDivisor;
  logic [IDX_W-1:0]       rrPointer;

  logic accept;
  logic terminal;
  logic tickNext;
  logic cfgReadyNext;
  logic runningNext;

  logic [SLOTS-1:0] arbGrant;
  logic [IDX_W-1:0] arbIndex;
  logic             arbFound;

  assign accept = cfgValid & cfgReady;

  rr_slot_arbiter #(
    .SLOTS (SLOTS)
  ) u_arbiter (
    .request (slotRequest),
    .pointer (rrPointer),
    .grant   (arbGrant),
    .index   (arbIndex),
    .found   (arbFound)
  );

  always_ff @(posedge cmosClock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // A config accept outranks enable in both IDLE and RUN.
  always_comb begin
    nextState = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          nextState = ST_RELOAD;
        end else if (enable) begin
          nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          nextState = ST_RELOAD;
        end else if (!enable) begin
          nextState = ST_IDLE;
        end
      end
      ST_RELOAD: begin
        nextState = enable ? ST_RUN : ST_IDLE;
      end
      default: begin
        nextState = ST_IDLE;
      end
    endcase
  end

  // A terminal count that coincides with a config accept still produces its tick;
  // one that coincides with enable dropping does not, since the block goes idle.
  always_comb begin
    cfgReadyNext = (nextState != ST_RELOAD);
    runningNext  = (nextState == ST_RUN);
    terminal     = (state == ST_RUN) && (counter == divisor - ONE);
    tickNext     = terminal && (nextState != ST_IDLE);
  end

  always_ff @(posedge cmosClock) begin
    if (reset) begin
      cfgReady       <= 1'b0;
      running        <= 1'b0;
      tick           <= 1'b0;
      counter        <= '0;
      divisor        <= DIV_RESET;
      pendingDivisor <= DIV_RESET;
    end else begin
      cfgReady <= cfgReadyNext;
      running  <= runningNext;
      tick     <= tickNext;

      if (accept) begin
        pendingDivisor <= (cfgDivisor == '0) ? ONE : cfgDivisor;
      end

      if (state == ST_RELOAD) begin
        divisor <= pendingDivisor;
      end

      if ((state == ST_RUN) && (nextState == ST_RUN)) begin
        counter <= terminal ? '0 : counter + ONE;
      end else begin
        counter <= '0;
      end
    end
  end

  // Ownership changes only on the edge that raises tick; the pointer survives idle periods.
  always_ff @(posedge cmosClock) begin
    if (reset) begin
      slotGrant <= '0;
      slotIndex <= '0;
      rrPointer <= IDX_W'(SLOTS - 1);
    end else if (tickNext) begin
      if (arbFound) begin
        slotGrant <= arbGrant;
        slotIndex <= arbIndex;
        rrPointer <= arbIndex;
      end else begin
        slotGrant <= '0;
      end
    end else if (nextState != ST_RUN) begin
      slotGrant <= '0;
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Scenario bench for tick_scheduler: expected ticks (cycle, grant, index) are queued
// from a round-robin model as stimulus is applied and compared as ticks appear.
module tb_tick_scheduler;

  logic        cmosClock = 1'b0;
  logic        reset;
  logic        enable;
  logic        cfgValid;
  logic [19:0] cfgDivisor;
  logic        cfgReady;
  logic [3:0]  slotRequest;
  logic        tick;
  logic [3:0]  slotGrant;
  logic [1:0]  slotIndex;
  logic        running;

  int cyc      = 0;
  int checks   = 0;
  int errors   = 0;
  int modelPtr = 3;
  int modelIdx = 0;

  typedef struct {
    int         cycle;
    logic [3:0] grant;
    logic [1:0] index;
  } tickExp_t;

  tickExp_t expQ[$];

  tick_scheduler dut (
    .cmosClock   (cmosClock),
    .reset       (reset),
    .enable      (enable),
    .cfgValid    (cfgValid),
    .cfgDivisor  (cfgDivisor),
    .cfgReady    (cfgReady),
    .slotRequest (slotRequest),
    .tick        (tick),
    .slotGrant   (slotGrant),
    .slotIndex   (slotIndex),
    .running     (running)
  );

  always #5 cmosClock = ~cmosClock;

  always @(posedge cmosClock) cyc <= cyc + 1;

  task automatic doReset();
    reset       = 1'b1;
    enable      = 1'b0;
    cfgValid    = 1'b0;
    cfgDivisor  = '0;
    slotRequest = '0;
    expQ.delete();
    modelPtr = 3;
    modelIdx = 0;
    repeat (2) @(negedge cmosClock);
    reset = 1'b0;
    @(negedge cmosClock);
  endtask

  // Round-robin reference: first requester after the model pointer, looking forward.
  task automatic pushTick(input int atCycle, input logic [3:0] req);
    tickExp_t e;
    bit       hit;
    int       s;
    hit     = 1'b0;
    e.cycle = atCycle;
    e.grant = 4'b0000;
    e.index = 2'(modelIdx);
    for (int k = 1; k <= 4; k++) begin
      s = (modelPtr + k) % 4;
      if (!hit && req[s[1:0]]) begin
        hit      = 1'b1;
        modelPtr = s;
        modelIdx = s;
        e.grant  = 4'b0001 << s;
        e.index  = 2'(s);
      end
    end
    expQ.push_back(e);
  endtask

  task automatic waitTick(input int budget, output bit got, output int at,
                          output logic [3:0] g, output logic [1:0] ix);
    got = 1'b0;
    at  = 0;
    g   = '0;
    ix  = '0;
    for (int n = 0; n < budget && !got; n++) begin
      @(negedge cmosClock);
      if (tick === 1'b1) begin
        got = 1'b1;
        at  = cyc;
        g   = slotGrant;
        ix  = slotIndex;
      end
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    enable      = 1'b0;
    cfgValid    = 1'b0;
    cfgDivisor  = '0;
    slotRequest = '0;
    repeat (3) @(negedge cmosClock);
    checks++; if (cfgReady !== 1'b0) begin errors++; $display("FAIL reset_cfgReady: got %b want 0", cfgReady); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
    checks++; if (slotGrant !== 4'b0000) begin errors++; $display("FAIL reset_slotGrant: got %b want 0000", slotGrant); end
    checks++; if (slotIndex !== 2'd0) begin errors++; $display("FAIL reset_slotIndex: got %0d want 0", slotIndex); end
    reset = 1'b0;
    @(negedge cmosClock);
    checks++; if (cfgReady !== 1'b1) begin errors++; $display("FAIL post_reset_cfgReady: got %b want 1", cfgReady); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL post_reset_running: got %b want 0", running); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL post_reset_tick: got %b want 0", tick); end
  endtask

  // Config accepted mid-RUN, then reset in RELOAD: default divisor must govern the next run.
  task automatic test_reset_midrun();
    tickExp_t   e;
    bit         got;
    int         at;
    int         r;
    logic [3:0] g;
    logic [1:0] ix;
    enable      = 1'b1;
    slotRequest = 4'b1111;
    @(negedge cmosClock);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL midrun_running: got %b want 1", running); end
    @(negedge cmosClock);
    cfgValid   = 1'b1;
    cfgDivisor = 20'd9;
    @(negedge cmosClock);
    checks++; if (cfgReady !== 1'b0) begin errors++; $display("FAIL midrun_reload_ready: got %b want 0", cfgReady); end
    cfgValid = 1'b0;
    reset    = 1'b1;
    enable   = 1'b0;
    @(negedge cmosClock);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL midrun_reset_tick: got %b want 0", tick); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL midrun_reset_running: got %b want 0", running); end
    checks++; if (cfgReady !== 1'b0) begin errors++; $display("FAIL midrun_reset_cfgReady: got %b want 0", cfgReady); end
    checks++; if (slotGrant !== 4'b0000) begin errors++; $display("FAIL midrun_reset_slotGrant: got %b want 0000", slotGrant); end
    checks++; if (slotIndex !== 2'd0) begin errors++; $display("FAIL midrun_reset_slotIndex: got %0d want 0", slotIndex); end
    modelPtr = 3;
    modelIdx = 0;
    reset    = 1'b0;
    enable   = 1'b1;
    r        = cyc + 1;
    pushTick(r + 50000, 4'b1111);
    @(negedge cmosClock);
    checks++; if (running !== 1'b1 || cfgReady !== 1'b1) begin errors++; $display("FAIL midrun_restart: got running=%b cfgReady=%b want 1 1", running, cfgReady); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      waitTick(50010, got, at, g, ix);
      checks++;
      if (!got || at != e.cycle || g !== e.grant || ix !== e.index) begin
        errors++;
        $display("FAIL default_divisor_tick: got seen=%0d cycle=%0d grant=%b index=%0d want cycle=%0d grant=%b index=%0d",
                 got, at, g, ix, e.cycle, e.grant, e.index);
      end
    end
  endtask

  task automatic test_reconfig();
    tickExp_t   e;
    bit         got;
    int         at;
    int         r;
    logic [3:0] g;
    logic [1:0] ix;
    @(negedge cmosClock);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_pulse_width: got %b want 0", tick); end
    cfgValid   = 1'b1;
    cfgDivisor = 20'd4;
    @(negedge cmosClock);
    checks++; if (cfgReady !== 1'b0 || running !== 1'b0 || slotGrant !== 4'b0000) begin
      errors++; $display("FAIL reconfig_reload: got cfgReady=%b running=%b grant=%b want 0 0 0000", cfgReady, running, slotGrant);
    end
    cfgValid = 1'b0;
    @(negedge cmosClock);
    checks++; if (cfgReady !== 1'b1 || running !== 1'b1) begin
      errors++; $display("FAIL reconfig_resume: got cfgReady=%b running=%b want 1 1", cfgReady, running);
    end
    r = cyc;
    for (int k = 1; k <= 4; k++) pushTick(r + 4 * k, 4'b1111);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      waitTick(8, got, at, g, ix);
      checks++;
      if (!got || at != e.cycle || g !== e.grant || ix !== e.index) begin
        errors++;
        $display("FAIL divisor4_tick: got seen=%0d cycle=%0d grant=%b index=%0d want cycle=%0d grant=%b index=%0d",
                 got, at, g, ix, e.cycle, e.grant, e.index);
      end
    end
  endtask

  task automatic test_divisor_zero();
    tickExp_t   e;
    bit         got;
    int         at;
    int         r;
    logic [3:0] g;
    logic [1:0] ix;
    cfgValid   = 1'b1;
    cfgDivisor = 20'd0;
    @(negedge cmosClock);
    cfgValid = 1'b0;
    @(negedge cmosClock);
    checks++; if (running !== 1'b1 || tick !== 1'b0) begin
      errors++; $display("FAIL div0_resume: got running=%b tick=%b want 1 0", running, tick);
    end
    r = cyc;
    for (int k = 1; k <= 5; k++) pushTick(r + k, 4'b1111);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      waitTick(3, got, at, g, ix);
      checks++;
      if (!got || at != e.cycle || g !== e.grant || ix !== e.index) begin
        errors++;
        $display("FAIL divisor1_tick: got seen=%0d cycle=%0d grant=%b index=%0d want cycle=%0d grant=%b index=%0d",
                 got, at, g, ix, e.cycle, e.grant, e.index);
      end
    end
    enable = 1'b0;
    @(negedge cmosClock);
    checks++; if (tick !== 1'b0 || running !== 1'b0 || slotGrant !== 4'b0000 || slotIndex !== 2'(modelIdx)) begin
      errors++;
      $display("FAIL stop_outputs: got tick=%b running=%b grant=%b index=%0d want 0 0 0000 %0d",
               tick, running, slotGrant, slotIndex, modelIdx);
    end
  endtask

  task automatic test_two_requesters();
    tickExp_t   e;
    bit         got;
    int         at;
    int         r;
    logic [3:0] g;
    logic [1:0] ix;
    doReset();
    cfgValid    = 1'b1;
    cfgDivisor  = 20'd3;
    enable      = 1'b1;
    slotRequest = 4'b0101;
    @(negedge cmosClock);
    cfgValid = 1'b0;
    checks++; if (cfgReady !== 1'b0) begin errors++; $display("FAIL idle_cfg_reload: got %b want 0", cfgReady); end
    @(negedge cmosClock);
    r = cyc;
    for (int k = 1; k <= 4; k++) pushTick(r + 3 * k, 4'b0101);
    for (int phase = 0; phase < 3; phase++) begin
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        waitTick(6, got, at, g, ix);
        checks++;
        if (!got || at != e.cycle || g !== e.grant || ix !== e.index) begin
          errors++;
          $display("FAIL two_req_tick: got seen=%0d cycle=%0d grant=%b index=%0d want cycle=%0d grant=%b index=%0d",
                   got, at, g, ix, e.cycle, e.grant, e.index);
        end
      end
      if (phase == 0) begin
        slotRequest = 4'b0000;
        pushTick(r + 15, 4'b0000);
      end else if (phase == 1) begin
        slotRequest = 4'b0101;
        pushTick(r + 18, 4'b0101);
      end
    end
  endtask

  task automatic test_tc_config();
    tickExp_t   e;
    bit         got;
    int         at;
    int         r;
    logic [3:0] g;
    logic [1:0] ix;
    doReset();
    cfgValid    = 1'b1;
    cfgDivisor  = 20'd3;
    enable      = 1'b1;
    slotRequest = 4'b1111;
    @(negedge cmosClock);
    cfgValid = 1'b0;
    @(negedge cmosClock);
    r = cyc;
    repeat (2) @(negedge cmosClock);
    cfgValid   = 1'b1;
    cfgDivisor = 20'd5;
    pushTick(r + 3, 4'b1111);
    e = expQ.pop_front();
    @(negedge cmosClock);
    checks++; if (tick !== 1'b1 || cyc != e.cycle || slotGrant !== e.grant || slotIndex !== e.index) begin
      errors++;
      $display("FAIL tc_cfg_tick: got tick=%b cycle=%0d grant=%b index=%0d want 1 %0d %b %0d",
               tick, cyc, slotGrant, slotIndex, e.cycle, e.grant, e.index);
    end
    checks++; if (cfgReady !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL tc_cfg_reload: got cfgReady=%b running=%b want 0 0", cfgReady, running);
    end
    cfgValid = 1'b0;
    @(negedge cmosClock);
    checks++; if (tick !== 1'b0 || running !== 1'b1) begin
      errors++; $display("FAIL tc_cfg_resume: got tick=%b running=%b want 0 1", tick, running);
    end
    r = cyc;
    pushTick(r + 5, 4'b1111);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      waitTick(8, got, at, g, ix);
      checks++;
      if (!got || at != e.cycle || g !== e.grant || ix !== e.index) begin
        errors++;
        $display("FAIL tc_cfg_next_tick: got seen=%0d cycle=%0d grant=%b index=%0d want cycle=%0d grant=%b index=%0d",
                 got, at, g, ix, e.cycle, e.grant, e.index);
      end
    end
    @(negedge cmosClock);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tc_cfg_pulse_width: got %b want 0", tick); end
  endtask

  task automatic test_enable_pause();
    tickExp_t   e;
    bit         got;
    int         at;
    int         r;
    int         tickSeen;
    logic [3:0] g;
    logic [1:0] ix;
    doReset();
    cfgValid    = 1'b1;
    cfgDivisor  = 20'd6;
    enable      = 1'b1;
    slotRequest = 4'b1111;
    @(negedge cmosClock);
    cfgValid = 1'b0;
    @(negedge cmosClock);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL pause_start_running: got %b want 1", running); end
    repeat (3) @(negedge cmosClock);
    enable = 1'b0;
    @(negedge cmosClock);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_idle_running: got %b want 0", running); end
    tickSeen = 0;
    repeat (10) begin
      @(negedge cmosClock);
      if (tick !== 1'b0) tickSeen++;
    end
    checks++; if (tickSeen != 0) begin errors++; $display("FAIL pause_idle_ticks: got %0d want 0", tickSeen); end
    enable = 1'b1;
    r      = cyc + 1;
    pushTick(r + 6, 4'b1111);
    @(negedge cmosClock);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL pause_resume_running: got %b want 1", running); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      waitTick(10, got, at, g, ix);
      checks++;
      if (!got || at != e.cycle || g !== e.grant || ix !== e.index) begin
        errors++;
        $display("FAIL pause_resume_tick: got seen=%0d cycle=%0d grant=%b index=%0d want cycle=%0d grant=%b index=%0d",
                 got, at, g, ix, e.cycle, e.grant, e.index);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_midrun();
    test_reconfig();
    test_divisor_zero();
    test_two_requesters();
    test_tc_config();
    test_enable_pause();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
